// File: rtl/vc_credit_demux_pkg.sv
// Shared constants and helpers for the credit-flow-controlled VC demux.
// The one-hot check is shared with the other router blocks that take a VC select.
package vc_credit_demux_pkg;

    localparam int DEFAULT_CREDIT_DEPTH = 4;
    localparam int MAX_SEL_WIDTH        = 32;

    // Narrower selects are zero-extended to MAX_SEL_WIDTH before the check.
    function automatic logic is_onehot(input logic [MAX_SEL_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - MAX_SEL_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/vc_credit_demux_counter.sv
// Per-VC credit counter: one count per free downstream buffer slot.
// A flit sent and a credit returned in the same cycle cancel out.
module vc_credit_counter #(
    parameter int CREDIT_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dec,
    input  logic inc,
    output logic avail,
    output logic overflow
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= FULL;
        end else begin
            case ({inc, dec})
                2'b10:   if (count != FULL) count <= count + CW'(1);
                2'b01:   if (count != '0)   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign avail    = (count != '0);
    // A credit with no room to hold it means downstream returned more than it owns.
    assign overflow = inc && !dec && (count == FULL);

endmodule

// File: rtl/vc_credit_demux.sv
// Registered one-hot demux from the input-port arbiter to per-VC downstream buffers,
// with per-VC credit back-pressure and sticky select/credit error flags.
module vc_credit_demux
    import vc_credit_demux_pkg::*;
#(
    parameter int IN_WIDTH     = 5,
    parameter int SEL_WIDTH    = 4,
    parameter int OUT_WIDTH    = IN_WIDTH * SEL_WIDTH,
    parameter int CREDIT_DEPTH = DEFAULT_CREDIT_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 demux_valid,
    input  logic [SEL_WIDTH-1:0] demux_sel,
    input  logic [IN_WIDTH-1:0]  demux_in,
    output logic                 demux_ready,
    input  logic [SEL_WIDTH-1:0] credit_in,
    output logic [OUT_WIDTH-1:0] demux_out,
    output logic [SEL_WIDTH-1:0] out_valid,
    output logic [SEL_WIDTH-1:0] credit_avail,
    output logic                 err_sel,
    output logic                 err_credit
);

    logic                 sel_legal;
    logic                 accept;
    logic [SEL_WIDTH-1:0] dec;
    logic [SEL_WIDTH-1:0] overflow;
    logic [OUT_WIDTH-1:0] out_next;

    assign sel_legal   = is_onehot(MAX_SEL_WIDTH'(demux_sel));
    // Ready looks only at registered credit state, so a returned credit helps next cycle.
    assign demux_ready = sel_legal && ((demux_sel & credit_avail) != '0);
    assign accept      = demux_valid && demux_ready;
    assign dec         = accept ? demux_sel : '0;

    for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_vc
        vc_credit_counter #(
            .CREDIT_DEPTH(CREDIT_DEPTH)
        ) u_credit (
            .clk     (clk),
            .reset   (reset),
            .dec     (dec[i]),
            .inc     (credit_in[i]),
            .avail   (credit_avail[i]),
            .overflow(overflow[i])
        );
    end

    always_comb begin
        out_next = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            if (dec[i]) out_next[i*IN_WIDTH +: IN_WIDTH] = demux_in;
        end
    end

    // Outputs are strobes, not holding registers: idle cycles drive zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            demux_out  <= '0;
            out_valid  <= '0;
            err_sel    <= 1'b0;
            err_credit <= 1'b0;
        end else begin
            demux_out  <= out_next;
            out_valid  <= dec;
            err_sel    <= err_sel || (demux_valid && !sel_legal);
            err_credit <= err_credit || (overflow != '0);
        end
    end

endmodule
